// File: rtl/conv_addr_gen_pkg.sv
// Shared constants for the convolution address generator: FSM state codes
// and default bus widths used by conv_addr_gen and conv_win_counter.
package conv_addr_gen_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int DEF_BITWIDTH_MAX_IF_SIZE = 22;
  localparam int DEF_BITWIDTH_MAX_W_SIZE  = 9;
  localparam int DEF_BITWIDTH_IF_ROWS     = 10;
  localparam int DEF_BITWIDTH_IF_COLUMS   = 11;
  localparam int DEF_BITWIDTH_W_COLUMS    = 4;
  localparam int DEF_BITWIDTH_STRIDE      = 4;

endpackage

// File: rtl/conv_win_counter.sv
// Nested kernel col / row / channel counters producing the weight address of one window.
// Latency: registered, next value one cycle after advance.
// Backpressure: state only moves on advance; holds otherwise.
module conv_win_counter
  import conv_addr_gen_pkg::*;
#(
  parameter int BITWIDTH_MAX_W_SIZE = DEF_BITWIDTH_MAX_W_SIZE,
  parameter int BITWIDTH_W_COLUMS   = DEF_BITWIDTH_W_COLUMS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           advance,
  input  logic [BITWIDTH_MAX_W_SIZE-1:0] w_size_1,
  input  logic [BITWIDTH_MAX_W_SIZE-1:0] w_roxcl_1,
  input  logic [BITWIDTH_W_COLUMS-1:0]   w_colums_1,
  output logic [BITWIDTH_MAX_W_SIZE-1:0] w_addr,
  output logic                           win_last,
  output logic                           k_wrap,
  output logic                           ch_wrap
);

  localparam logic [BITWIDTH_W_COLUMS-1:0]   K_ONE = 1;
  localparam logic [BITWIDTH_MAX_W_SIZE-1:0] W_ONE = 1;

  logic [BITWIDTH_W_COLUMS-1:0]   k;
  // Offset inside the current channel plane of the kernel (0..Wr*Wc-1); its
  // wrap marks the end of a channel without needing Wr itself.
  logic [BITWIDTH_MAX_W_SIZE-1:0] ch_off;

  assign k_wrap  = (k == w_colums_1);
  assign ch_wrap = (ch_off == w_roxcl_1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k        <= '0;
      ch_off   <= '0;
      w_addr   <= '0;
      win_last <= 1'b0;
    end else if (clear || (advance && win_last)) begin
      k        <= '0;
      ch_off   <= '0;
      w_addr   <= '0;
      win_last <= (w_size_1 == '0);
    end else if (advance) begin
      k        <= k_wrap ? '0 : k + K_ONE;
      ch_off   <= ch_wrap ? '0 : ch_off + W_ONE;
      w_addr   <= w_addr + W_ONE;
      win_last <= ((w_addr + W_ONE) == w_size_1);
    end
  end

endmodule

// File: rtl/conv_addr_gen.sv
// Walks the conv window over the IF map, one (IF addr, W addr) pair per beat; optional CONV_ADDR_GEN_STALL_CNT_EN adds a stall counter.
// Latency: first beat valid the cycle after LOAD; Done pulses the cycle after the last accepted beat.
// Backpressure: valid/ready, all outputs held while Valid && !Ready.
module conv_addr_gen
  import conv_addr_gen_pkg::*;
#(
  parameter int BITWIDTH_MAX_IF_SIZE = DEF_BITWIDTH_MAX_IF_SIZE,
  parameter int BITWIDTH_MAX_W_SIZE  = DEF_BITWIDTH_MAX_W_SIZE,
  parameter int BITWIDTH_IF_ROWS     = DEF_BITWIDTH_IF_ROWS,
  parameter int BITWIDTH_IF_COLUMS   = DEF_BITWIDTH_IF_COLUMS,
  parameter int BITWIDTH_W_COLUMS    = DEF_BITWIDTH_W_COLUMS,
  parameter int BITWIDTH_STRIDE      = DEF_BITWIDTH_STRIDE
) (
  input  logic                            CONV_ADDR_GEN_CLOCK_50,
  input  logic                            CONV_ADDR_GEN_RESET_InLow,
  input  logic                            CONV_ADDR_GEN_Start,
  input  logic [BITWIDTH_IF_ROWS-1:0]     CONV_ADDR_GEN_If_Rows,
  input  logic [BITWIDTH_IF_COLUMS-1:0]   CONV_ADDR_GEN_If_Colums,
  input  logic [BITWIDTH_IF_COLUMS-1:0]   CONV_ADDR_GEN_Of_Colums,
  input  logic [BITWIDTH_STRIDE-1:0]      CONV_ADDR_GEN_Stride,
  input  logic [BITWIDTH_MAX_W_SIZE-1:0]  CONV_ADDR_GEN_W_Size_1,
  input  logic [BITWIDTH_MAX_W_SIZE-1:0]  CONV_ADDR_GEN_W_ROXCL_1,
  input  logic [BITWIDTH_W_COLUMS-1:0]    CONV_ADDR_GEN_W_Colums_1,
  input  logic [BITWIDTH_MAX_IF_SIZE-1:0] CONV_ADDR_GEN_Of_Size_1,
  input  logic                            CONV_ADDR_GEN_Ready,
  output logic                            CONV_ADDR_GEN_Valid,
  output logic [BITWIDTH_MAX_IF_SIZE-1:0] CONV_ADDR_GEN_If_Addr,
  output logic [BITWIDTH_MAX_W_SIZE-1:0]  CONV_ADDR_GEN_W_Addr,
  output logic                            CONV_ADDR_GEN_Win_Last,
  output logic [BITWIDTH_MAX_IF_SIZE-1:0] CONV_ADDR_GEN_Of_Addr,
  output logic                            CONV_ADDR_GEN_Busy,
  output logic                            CONV_ADDR_GEN_Done
`ifdef CONV_ADDR_GEN_STALL_CNT_EN
  ,
  output logic [31:0]                     CONV_ADDR_GEN_Stall_Cnt
`endif
);

  localparam int IFW = BITWIDTH_MAX_IF_SIZE;
  localparam logic [IFW-1:0]                IF_ONE  = 1;
  localparam logic [BITWIDTH_IF_COLUMS-1:0] COL_ONE = 1;
  localparam logic [BITWIDTH_STRIDE-1:0]    S_ONE   = 1;

  logic clk;
  logic rst_n;
  assign clk   = CONV_ADDR_GEN_CLOCK_50;
  assign rst_n = CONV_ADDR_GEN_RESET_InLow;

  logic [1:0] state;

  logic [BITWIDTH_IF_ROWS-1:0]    cfg_if_rows;
  logic [BITWIDTH_IF_COLUMS-1:0]  cfg_if_cols;
  logic [BITWIDTH_IF_COLUMS-1:0]  cfg_of_cols;
  logic [BITWIDTH_STRIDE-1:0]     cfg_stride;
  logic [BITWIDTH_MAX_W_SIZE-1:0] cfg_w_size_1;
  logic [BITWIDTH_MAX_W_SIZE-1:0] cfg_w_roxcl_1;
  logic [BITWIDTH_W_COLUMS-1:0]   cfg_w_cols_1;
  logic [IFW-1:0]                 cfg_of_size_1;

  logic [BITWIDTH_STRIDE-1:0]     stride_eff;
  logic [IFW-1:0]                 plane;
  logic [IFW-1:0]                 s_ic;

  // Window origin = row_org + col_org; ch_base/row_ptr step from it by adds.
  logic [IFW-1:0]                 row_org, col_org, ch_base, row_ptr;
  logic [BITWIDTH_IF_COLUMS-1:0]  ocol;
  logic [IFW-1:0]                 nxt_row_org, nxt_col_org, nxt_ch_base, nxt_row_ptr, nxt_if;
  logic [BITWIDTH_IF_COLUMS-1:0]  nxt_ocol;

  logic valid, busy, done;
  logic [IFW-1:0] if_addr, of_addr;
  logic [BITWIDTH_MAX_W_SIZE-1:0] w_addr;
  logic win_last, k_wrap, ch_wrap;
  logic adv, last_beat;

  assign stride_eff = (cfg_stride == '0) ? S_ONE : cfg_stride;
  assign adv        = (state == ST_RUN) && valid && CONV_ADDR_GEN_Ready;
  assign last_beat  = win_last && (of_addr == cfg_of_size_1);

  conv_win_counter #(
    .BITWIDTH_MAX_W_SIZE(BITWIDTH_MAX_W_SIZE),
    .BITWIDTH_W_COLUMS  (BITWIDTH_W_COLUMS)
  ) u_win (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (state == ST_LOAD),
    .advance   (adv),
    .w_size_1  (cfg_w_size_1),
    .w_roxcl_1 (cfg_w_roxcl_1),
    .w_colums_1(cfg_w_cols_1),
    .w_addr    (w_addr),
    .win_last  (win_last),
    .k_wrap    (k_wrap),
    .ch_wrap   (ch_wrap)
  );

  always_comb begin
    nxt_row_org = row_org;
    nxt_col_org = col_org;
    nxt_ocol    = ocol;
    nxt_ch_base = ch_base;
    nxt_row_ptr = row_ptr;
    nxt_if      = if_addr + IF_ONE;
    if (k_wrap) begin
      if (!ch_wrap) begin
        nxt_row_ptr = row_ptr + IFW'(cfg_if_cols);
        nxt_if      = nxt_row_ptr;
      end else if (!win_last) begin
        nxt_ch_base = ch_base + plane;
        nxt_row_ptr = nxt_ch_base;
        nxt_if      = nxt_ch_base;
      end else begin
        if (ocol == cfg_of_cols - COL_ONE) begin
          nxt_ocol    = '0;
          nxt_col_org = '0;
          nxt_row_org = row_org + s_ic;
        end else begin
          nxt_ocol    = ocol + COL_ONE;
          nxt_col_org = col_org + IFW'(stride_eff);
        end
        nxt_ch_base = nxt_row_org + nxt_col_org;
        nxt_row_ptr = nxt_ch_base;
        nxt_if      = nxt_ch_base;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cfg_if_rows   <= '0;
      cfg_if_cols   <= '0;
      cfg_of_cols   <= '0;
      cfg_stride    <= '0;
      cfg_w_size_1  <= '0;
      cfg_w_roxcl_1 <= '0;
      cfg_w_cols_1  <= '0;
      cfg_of_size_1 <= '0;
      plane         <= '0;
      s_ic          <= '0;
      row_org       <= '0;
      col_org       <= '0;
      ch_base       <= '0;
      row_ptr       <= '0;
      ocol          <= '0;
      valid         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      if_addr       <= '0;
      of_addr       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (CONV_ADDR_GEN_Start) begin
            cfg_if_rows   <= CONV_ADDR_GEN_If_Rows;
            cfg_if_cols   <= CONV_ADDR_GEN_If_Colums;
            cfg_of_cols   <= CONV_ADDR_GEN_Of_Colums;
            cfg_stride    <= CONV_ADDR_GEN_Stride;
            cfg_w_size_1  <= CONV_ADDR_GEN_W_Size_1;
            cfg_w_roxcl_1 <= CONV_ADDR_GEN_W_ROXCL_1;
            cfg_w_cols_1  <= CONV_ADDR_GEN_W_Colums_1;
            cfg_of_size_1 <= CONV_ADDR_GEN_Of_Size_1;
            busy          <= 1'b1;
            state         <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          plane   <= IFW'(cfg_if_rows) * IFW'(cfg_if_cols);
          s_ic    <= IFW'(stride_eff) * IFW'(cfg_if_cols);
          row_org <= '0;
          col_org <= '0;
          ch_base <= '0;
          row_ptr <= '0;
          ocol    <= '0;
          if_addr <= '0;
          of_addr <= '0;
          valid   <= 1'b1;
          state   <= ST_RUN;
        end
        ST_RUN: begin
          if (adv) begin
            if (last_beat) begin
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              row_org <= nxt_row_org;
              col_org <= nxt_col_org;
              ocol    <= nxt_ocol;
              ch_base <= nxt_ch_base;
              row_ptr <= nxt_row_ptr;
              if_addr <= nxt_if;
              if (win_last) of_addr <= of_addr + IF_ONE;
            end
          end
        end
        default: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CONV_ADDR_GEN_STALL_CNT_EN
  logic [31:0] stall_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == ST_LOAD) begin
      stall_cnt <= '0;
    end else if ((state == ST_RUN) && valid && !CONV_ADDR_GEN_Ready) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
  assign CONV_ADDR_GEN_Stall_Cnt = stall_cnt;
`endif

  assign CONV_ADDR_GEN_Valid    = valid;
  assign CONV_ADDR_GEN_If_Addr  = if_addr;
  assign CONV_ADDR_GEN_W_Addr   = w_addr;
  assign CONV_ADDR_GEN_Win_Last = win_last;
  assign CONV_ADDR_GEN_Of_Addr  = of_addr;
  assign CONV_ADDR_GEN_Busy     = busy;
  assign CONV_ADDR_GEN_Done     = done;

endmodule

// File: tb/tb_conv_addr_gen.sv
// Bench for conv_addr_gen: table of layer shapes plus random shapes/backpressure,
// every beat compared against a loop-nest model of the convolution walk.
module tb_conv_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  if_rows;
  logic [10:0] if_cols, of_cols;
  logic [3:0]  stride;
  logic [8:0]  w_size_1, w_roxcl_1;
  logic [3:0]  w_cols_1;
  logic [21:0] of_size_1;
  logic        ready;
  logic        valid, win_last, busy, done;
  logic [21:0] if_addr, of_addr;
  logic [8:0]  w_addr;
`ifdef CONV_ADDR_GEN_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  conv_addr_gen dut (
    .CONV_ADDR_GEN_CLOCK_50   (clk),
    .CONV_ADDR_GEN_RESET_InLow(rst_n),
    .CONV_ADDR_GEN_Start      (start),
    .CONV_ADDR_GEN_If_Rows    (if_rows),
    .CONV_ADDR_GEN_If_Colums  (if_cols),
    .CONV_ADDR_GEN_Of_Colums  (of_cols),
    .CONV_ADDR_GEN_Stride     (stride),
    .CONV_ADDR_GEN_W_Size_1   (w_size_1),
    .CONV_ADDR_GEN_W_ROXCL_1  (w_roxcl_1),
    .CONV_ADDR_GEN_W_Colums_1 (w_cols_1),
    .CONV_ADDR_GEN_Of_Size_1  (of_size_1),
    .CONV_ADDR_GEN_Ready      (ready),
    .CONV_ADDR_GEN_Valid      (valid),
    .CONV_ADDR_GEN_If_Addr    (if_addr),
    .CONV_ADDR_GEN_W_Addr     (w_addr),
    .CONV_ADDR_GEN_Win_Last   (win_last),
    .CONV_ADDR_GEN_Of_Addr    (of_addr),
    .CONV_ADDR_GEN_Busy       (busy),
    .CONV_ADDR_GEN_Done       (done)
`ifdef CONV_ADDR_GEN_STALL_CNT_EN
    ,
    .CONV_ADDR_GEN_Stall_Cnt  (stall_cnt)
`endif
  );

  typedef struct {
    int ir, ic, wr, wc, wch, s, orr, oc;
    int exp_beats;   // -1: take from model
    int nb;
    int base[4];     // If_Addr of the first beat of windows 0..nb-1
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  int exp_if[$];
  int exp_w[$];
  int exp_last[$];
  int exp_of[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Straight loop nest over (pixel, channel, kernel row, kernel col).
  task automatic build_model(input vec_t v);
    int se, plane, wsz;
    se    = (v.s == 0) ? 1 : v.s;
    plane = v.ir * v.ic;
    wsz   = v.wr * v.wc * v.wch;
    exp_if.delete(); exp_w.delete(); exp_last.delete(); exp_of.delete();
    for (int p = 0; p < v.orr * v.oc; p++)
      for (int c = 0; c < v.wch; c++)
        for (int r = 0; r < v.wr; r++)
          for (int k = 0; k < v.wc; k++) begin
            int w;
            w = c * v.wr * v.wc + r * v.wc + k;
            exp_if.push_back(c * plane + ((p / v.oc) * se + r) * v.ic + (p % v.oc) * se + k);
            exp_w.push_back(w);
            exp_last.push_back(w == wsz - 1);
            exp_of.push_back(p);
          end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_valid"}, {63'd0, valid}, 64'd0);
    chk({tag, "_busy"},  {63'd0, busy},  64'd0);
    chk({tag, "_done"},  {63'd0, done},  64'd0);
    chk({tag, "_addrs"}, {if_addr, w_addr, win_last, of_addr}, 64'd0);
`ifdef CONV_ADDR_GEN_STALL_CNT_EN
    chk({tag, "_stall_cnt"}, {32'd0, stall_cnt}, 64'd0);
`endif
  endtask

  // rmode 0: Ready tied high, 1: random 50% Ready.
  task automatic run(input vec_t v, input int rmode, input int reset_at, input int inject);
    int wsz, nbeats, idx, cyc, stalls, vcyc;
    bit prev_stall, finished;
    logic [53:0] held;
    build_model(v);
    wsz    = v.wr * v.wc * v.wch;
    nbeats = (v.exp_beats < 0) ? exp_if.size() : v.exp_beats;
    @(negedge clk);
    if_rows   = 10'(v.ir);
    if_cols   = 11'(v.ic);
    of_cols   = 11'(v.oc);
    stride    = 4'(v.s);
    w_size_1  = 9'(wsz - 1);
    w_roxcl_1 = 9'(v.wr * v.wc - 1);
    w_cols_1  = 4'(v.wc - 1);
    of_size_1 = 22'(v.orr * v.oc - 1);
    start     = 1'b1;
    ready     = (rmode == 0);
    @(negedge clk);
    start = 1'b0;
    chk("load_busy_novalid", {62'd0, busy, valid}, 64'd2);
    idx = 0; cyc = 0; stalls = 0; vcyc = 0; prev_stall = 0; finished = 0; held = '0;
    while (cyc < 4000 && !finished) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) chk("first_beat_valid", {63'd0, valid}, 64'd1);
      if (done) begin
        chk("done_valid_low", {62'd0, valid, busy}, 64'd0);
        chk("beat_count", 64'(idx), 64'(nbeats));
        if (rmode == 0) chk("one_beat_per_cycle", 64'(vcyc), 64'(nbeats));
        @(negedge clk);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
`ifdef CONV_ADDR_GEN_STALL_CNT_EN
        chk("stall_cnt", {32'd0, stall_cnt}, 64'(stalls));
`endif
        finished = 1;
      end else if (valid) begin
        vcyc++;
        if (prev_stall) chk("stable_while_stalled", {10'd0, if_addr, w_addr, win_last, of_addr}, {10'd0, held});
        if (idx < exp_if.size()) begin
          chk($sformatf("beat%0d_if_w_last_of", idx),
              {10'd0, if_addr, w_addr, win_last, of_addr},
              {10'd0, 22'(exp_if[idx]), 9'(exp_w[idx]), 1'(exp_last[idx]), 22'(exp_of[idx])});
        end else begin
          chk("extra_beat", 64'(idx), 64'(exp_if.size() - 1));
        end
        if (!prev_stall && (idx % wsz) == 0 && (idx / wsz) < v.nb)
          chk($sformatf("win%0d_base", idx / wsz), {42'd0, if_addr}, 64'(v.base[idx / wsz]));
        chk("busy_in_run", {63'd0, busy}, 64'd1);
        if (idx == reset_at && !prev_stall) begin
          rst_n = 1'b0;
          #1;
          check_cleared("reset_mid_run");
          repeat (2) @(posedge clk);
          #1;
          check_cleared("reset_held");
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        if (inject != 0 && idx == 5) begin
          start     = 1'b1;
          if_cols   = 11'd7;
          of_size_1 = 22'd1;
          w_size_1  = 9'd0;
          stride    = 4'd3;
        end
        ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        held  = {if_addr, w_addr, win_last, of_addr};
        if (ready) begin
          idx++;
          prev_stall = 0;
        end else begin
          stalls++;
          prev_stall = 1;
        end
      end
    end
    if (!finished) chk("timeout_waiting_done", 64'(cyc), 64'd0);
  endtask

  vec_t tbl[5];

  initial begin
    rst_n = 1'b0; start = 1'b0; ready = 1'b0;
    if_rows = '0; if_cols = '0; of_cols = '0; stride = '0;
    w_size_1 = '0; w_roxcl_1 = '0; w_cols_1 = '0; of_size_1 = '0;

    //           ir ic wr wc wch s orr oc beats nb  bases
    tbl[0] = '{4, 4, 2, 2, 1, 1, 3, 3, 36, 4, '{0, 1, 2, 4}};
    tbl[1] = '{3, 3, 2, 2, 2, 1, 2, 2, 32, 4, '{0, 1, 3, 4}};
    tbl[2] = '{4, 4, 2, 2, 1, 2, 2, 2, 16, 4, '{0, 2, 8, 10}};
    tbl[3] = '{2, 3, 1, 1, 1, 0, 2, 3,  6, 4, '{0, 1, 2, 3}};
    tbl[4] = '{3, 3, 3, 3, 1, 1, 1, 1,  9, 1, '{0, 0, 0, 0}};

    #12;
    check_cleared("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run(tbl[i], 0, -1, 0);

    run(tbl[0], 0, 10, 0);   // reset at beat 10
    run(tbl[0], 0, -1, 1);   // full replay, with Start pulsed mid-run
    run(tbl[0], 1, -1, 0);
    run(tbl[1], 1, -1, 0);
    run(tbl[4], 1, -1, 0);

    for (int n = 0; n < 6; n++) begin
      vec_t rv;
      int se;
      rv.ir  = int'($urandom_range(3, 6));
      rv.ic  = int'($urandom_range(3, 7));
      rv.wr  = int'($urandom_range(1, 3));
      rv.wc  = int'($urandom_range(1, 3));
      rv.wch = int'($urandom_range(1, 2));
      rv.s   = int'($urandom_range(0, 2));
      se     = (rv.s == 0) ? 1 : rv.s;
      rv.orr = (rv.ir - rv.wr) / se + 1;
      rv.oc  = (rv.ic - rv.wc) / se + 1;
      rv.exp_beats = -1;
      rv.nb  = 0;
      rv.base = '{0, 0, 0, 0};
      run(rv, 1, -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
